// File: rtl/single_port_block_ram_if.sv
// Bus bundle for single_port_block_ram: shared address, write/read strobes and data.
// The master drives strobes, address and write data; the slave (the RAM) returns data_out.
interface single_port_block_ram_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 1024
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic             write_en;
   logic             read_en;
   logic [WIDTH-1:0] data_in;
   logic [AW-1:0]    addr;
   logic [WIDTH-1:0] data_out;

   modport master (
      output write_en,
      output read_en,
      output data_in,
      output addr,
      input  data_out
   );

   modport slave (
      input  write_en,
      input  read_en,
      input  data_in,
      input  addr,
      output data_out
   );
endinterface

// File: rtl/single_port_block_ram.sv
// Single-port synchronous RAM, read-first on collision, registered read data, array not reset.
// Define BLOCK_RAM_OUT_REG_EN to add a second output register (2-cycle read latency).
module single_port_block_ram #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   single_port_block_ram_if.slave bus
);
   localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned AW_EXT = AW + 1;
   localparam logic [AW_EXT-1:0] DEPTH_EXT = AW_EXT'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_q;
   logic             in_range_c;

   // Addresses past the last word exist only when DEPTH is not a power of two.
   generate
      if (DEPTH == (2 ** AW)) begin : g_full_range
         assign in_range_c = 1'b1;
      end else begin : g_partial_range
         assign in_range_c = ({1'b0, bus.addr} < DEPTH_EXT);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst && bus.write_en && in_range_c) begin
         mem_q[bus.addr] <= bus.data_in;
      end
   end

   // Non-blocking read of the old word gives read-first behaviour on a same-edge write.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q <= '0;
      end else if (bus.read_en) begin
         rd_q <= in_range_c ? mem_q[bus.addr] : '0;
      end
   end

`ifdef BLOCK_RAM_OUT_REG_EN
   logic             pend_q;
   logic [WIDTH-1:0] out_q;

   // Second stage loads the edge after a read and holds otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= 1'b0;
         out_q  <= '0;
      end else begin
         pend_q <= bus.read_en;
         if (pend_q) begin
            out_q <= rd_q;
         end
      end
   end

   assign bus.data_out = out_q;
`else
   assign bus.data_out = rd_q;
`endif

endmodule

// File: tb/tb_single_port_block_ram.sv
// Directed self-checking bench for single_port_block_ram (WIDTH=16, DEPTH=1000).
// Honours BLOCK_RAM_OUT_REG_EN by expecting the extra output cycle.
module tb_single_port_block_ram;
   localparam int unsigned WIDTH = 16;
   localparam int unsigned DEPTH = 1000;
`ifdef BLOCK_RAM_OUT_REG_EN
   localparam int unsigned LAT = 2;
`else
   localparam int unsigned LAT = 1;
`endif

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   single_port_block_ram_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   single_port_block_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [WIDTH-1:0] got,
                           input logic [WIDTH-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h expected 0x%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
   task automatic clk_step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [9:0] a, input logic [WIDTH-1:0] d);
      bus.write_en = 1'b1;
      bus.addr     = a;
      bus.data_in  = d;
      clk_step();
      bus.write_en = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [9:0] a, input logic [WIDTH-1:0] exp);
      bus.read_en = 1'b1;
      bus.addr    = a;
      clk_step();
      bus.read_en = 1'b0;
      for (int i = 1; i < int'(LAT); i++) clk_step();
      check_eq(tag, bus.data_out, exp);
   endtask

   function automatic logic [WIDTH-1:0] fill_pat(input int i);
      return WIDTH'(i * 37 + 16'h0100);
   endfunction

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      rst          = 1'b1;
      bus.write_en = 1'b0;
      bus.read_en  = 1'b0;
      bus.addr     = '0;
      bus.data_in  = '0;
      clk_step();
      clk_step();
      rst = 1'b0;
      check_eq("reset_dout", bus.data_out, 16'h0000);

      // Consecutive writes, idle, back-to-back reads, then hold.
      wr(10'd10, 16'hABCD);
      wr(10'd11, 16'h1234);
      repeat (10) clk_step();
      check_eq("idle_dout", bus.data_out, 16'h0000);
      bus.read_en = 1'b1;
      bus.addr    = 10'd10;
      clk_step();
      bus.addr = 10'd11;
      if (LAT == 1) check_eq("rd10", bus.data_out, 16'hABCD);
      else          check_eq("rd10_not_yet", bus.data_out, 16'h0000);
      clk_step();
      bus.read_en = 1'b0;
      bus.addr    = 10'd10;
      if (LAT == 1) check_eq("rd11", bus.data_out, 16'h1234);
      else          check_eq("rd10", bus.data_out, 16'hABCD);
      clk_step();
      if (LAT == 1) check_eq("hold_a", bus.data_out, 16'h1234);
      else          check_eq("rd11", bus.data_out, 16'h1234);
      clk_step();
      clk_step();
      check_eq("hold_b", bus.data_out, 16'h1234);

      // Same-edge write and read returns the old word.
      wr(10'd5, 16'h1111);
      bus.write_en = 1'b1;
      bus.read_en  = 1'b1;
      bus.addr     = 10'd5;
      bus.data_in  = 16'h2222;
      clk_step();
      bus.write_en = 1'b0;
      bus.read_en  = 1'b0;
      for (int i = 1; i < int'(LAT); i++) clk_step();
      check_eq("collide_old", bus.data_out, 16'h1111);
      rd_chk("collide_new", 10'd5, 16'h2222);

      // Reset overrides a simultaneous write and read; the array survives.
      rd_chk("pre_rst", 10'd10, 16'hABCD);
      rst          = 1'b1;
      bus.write_en = 1'b1;
      bus.read_en  = 1'b1;
      bus.addr     = 10'd10;
      bus.data_in  = 16'h5555;
      clk_step();
      rst          = 1'b0;
      bus.write_en = 1'b0;
      bus.read_en  = 1'b0;
      check_eq("rst_dout", bus.data_out, 16'h0000);
      clk_step();
      check_eq("rst_drop_rd", bus.data_out, 16'h0000);
      rd_chk("post_rst_mem", 10'd10, 16'hABCD);
      rd_chk("post_rst_m11", 10'd11, 16'h1234);

      // Fill every word, write out of range, then verify nothing moved.
      for (int i = 0; i < int'(DEPTH); i++) wr(10'(i), fill_pat(i));
      rd_chk("last_word", 10'd999, fill_pat(999));
      wr(10'd1010, 16'hBEEF);
      rd_chk("oor_read", 10'd1010, 16'h0000);
      rd_chk("first_word", 10'd0, fill_pat(0));
      rd_chk("oor_read_max", 10'd1023, 16'h0000);
      for (int i = 0; i < int'(DEPTH); i++) begin
         rd_chk($sformatf("scan_%0d", i), 10'(i), fill_pat(i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
